// File: rtl/mips_pkg.sv
// Shared definitions for the post-run data-memory dump engine:
// default widths and the dump FSM state encoding.
package mips_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 5;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RD   = 3'd1,
    ST_CAP  = 3'd2,
    ST_HOLD = 3'd3,
    ST_DONE = 3'd4
  } dump_state_t;

endpackage

// File: rtl/datamem_dump.sv
// Post-run data-memory dump engine. When the core raises fin, walks the
// inclusive range [start_addr, end_addr] through a synchronous read port and
// presents each word with its address on a valid/ready stream.
module datamem_dump
  import mips_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              pcclr,
  input  logic              fin,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [ADDR_W-1:0] end_addr,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] out_addr,
  output logic [DATA_W-1:0] out_data,
  output logic [ADDR_W:0]   words_sent,
  output logic              range_err,
  output logic              done
);

  dump_state_t       state, state_nxt;
  logic              fin_d;
  logic              trig;
  logic              hs;
  logic              at_last;
  logic [ADDR_W-1:0] cur;
  logic [ADDR_W-1:0] last;

  // Rising edge of fin; only acted on in IDLE, so edges mid-dump are ignored.
  assign trig    = fin & ~fin_d;
  // out_valid is only ever high in HOLD, so out_ready is ignored elsewhere.
  assign hs      = (state == ST_HOLD) && out_valid && out_ready;
  // Compare before incrementing so the top address terminates without wrap.
  assign at_last = (cur == last);

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!pcclr) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic and state-decoded outputs (read strobe, read address, done).
  always_comb begin
    state_nxt = state;
    mem_rd_en = 1'b0;
    mem_addr  = '0;
    done      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (trig) begin
          if (start_addr > end_addr) state_nxt = ST_DONE;
          else                       state_nxt = ST_RD;
        end
      end
      ST_RD: begin
        mem_rd_en = 1'b1;
        mem_addr  = cur;
        state_nxt = ST_CAP;
      end
      ST_CAP: begin
        state_nxt = ST_HOLD;
      end
      ST_HOLD: begin
        if (hs) begin
          if (at_last) state_nxt = ST_DONE;
          else         state_nxt = ST_RD;
        end
      end
      ST_DONE: begin
        done = 1'b1;
        if (!fin) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Delayed fin for edge detection.
  always_ff @(posedge clk) begin
    if (!pcclr) fin_d <= 1'b0;
    else        fin_d <= fin;
  end

  // Range latch, address walker, status counters and the presented word.
  always_ff @(posedge clk) begin
    if (!pcclr) begin
      cur        <= '0;
      last       <= '0;
      out_valid  <= 1'b0;
      out_addr   <= '0;
      out_data   <= '0;
      words_sent <= '0;
      range_err  <= 1'b0;
    end else begin
      if ((state == ST_IDLE) && trig) begin
        cur        <= start_addr;
        last       <= end_addr;
        words_sent <= '0;
        range_err  <= (start_addr > end_addr);
      end
      // Read data returns one cycle after the RD strobe, i.e. during CAP.
      if (state == ST_CAP) begin
        out_data  <= mem_rdata;
        out_addr  <= cur;
        out_valid <= 1'b1;
      end
      if (hs) begin
        out_valid  <= 1'b0;
        words_sent <= words_sent + (ADDR_W+1)'(1);
        if (!at_last) cur <= cur + ADDR_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_datamem_dump.sv
// Directed bench for datamem_dump with a behavioural synchronous memory
// preloaded with mem[i] = i*3.
module tb_datamem_dump;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;

  logic              clk;
  logic              pcclr;
  logic              fin;
  logic [ADDR_W-1:0] start_addr;
  logic [ADDR_W-1:0] end_addr;
  logic              mem_rd_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_rdata;
  logic              out_valid;
  logic              out_ready;
  logic [ADDR_W-1:0] out_addr;
  logic [DATA_W-1:0] out_data;
  logic [ADDR_W:0]   words_sent;
  logic              range_err;
  logic              done;

  logic [DATA_W-1:0] mem [2**ADDR_W];
  logic [ADDR_W-1:0] q_addr [$];
  logic [DATA_W-1:0] q_data [$];
  int                rd_cnt;
  int                tests;
  int                fails;

  datamem_dump #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk        (clk),
    .pcclr      (pcclr),
    .fin        (fin),
    .start_addr (start_addr),
    .end_addr   (end_addr),
    .mem_rd_en  (mem_rd_en),
    .mem_addr   (mem_addr),
    .mem_rdata  (mem_rdata),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_addr   (out_addr),
    .out_data   (out_data),
    .words_sent (words_sent),
    .range_err  (range_err),
    .done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: read issued in RD, data held stable through CAP.
  always @(negedge clk) begin
    if (mem_rd_en) mem_rdata <= mem[mem_addr];
  end

  // Stream and read-strobe monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (mem_rd_en) rd_cnt <= rd_cnt + 1;
    if (out_valid && out_ready) begin
      q_addr.push_back(out_addr);
      q_data.push_back(out_data);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_mon();
    q_addr.delete();
    q_data.delete();
    rd_cnt = 0;
  endtask

  task automatic wait_valid(input string tag);
    int n;
    n = 0;
    while (!out_valid && n < 50) begin
      tick();
      n++;
    end
    check(tag, 64'(out_valid), 64'(1));
  endtask

  task automatic wait_done(input string tag);
    int n;
    n = 0;
    while (!done && n < 200) begin
      tick();
      n++;
    end
    check(tag, 64'(done), 64'(1));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " mem_rd_en"},  64'(mem_rd_en),  64'(0));
    check({tag, " mem_addr"},   64'(mem_addr),   64'(0));
    check({tag, " out_valid"},  64'(out_valid),  64'(0));
    check({tag, " out_addr"},   64'(out_addr),   64'(0));
    check({tag, " out_data"},   64'(out_data),   64'(0));
    check({tag, " words_sent"}, 64'(words_sent), 64'(0));
    check({tag, " range_err"},  64'(range_err),  64'(0));
    check({tag, " done"},       64'(done),       64'(0));
  endtask

  task automatic check_stream_1to4(input string tag);
    check({tag, " count"}, 64'(q_addr.size()), 64'(4));
    for (int i = 0; i < 4; i++) begin
      check($sformatf("%s addr%0d", tag, i), 64'(q_addr[i]), 64'(i + 1));
      check($sformatf("%s data%0d", tag, i), 64'(q_data[i]), 64'((i + 1) * 3));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tests = 0;
    fails = 0;
    rd_cnt = 0;
    mem_rdata = '0;
    for (int i = 0; i < 2**ADDR_W; i++) mem[i] = DATA_W'(i * 3);

    // Reset state
    pcclr = 1'b0; fin = 1'b0; out_ready = 1'b0;
    start_addr = '0; end_addr = '0;
    tick(); tick();
    check_reset_outputs("reset");

    // Basic dump 1..4, ready high, latency 3 cycles from fin rising
    pcclr = 1'b1; start_addr = 5'd1; end_addr = 5'd4; out_ready = 1'b1;
    tick();
    clear_mon();
    fin = 1'b1;
    tick();
    check("lat c1 valid", 64'(out_valid), 64'(0));
    check("lat c1 rd_en", 64'(mem_rd_en), 64'(1));
    check("lat c1 addr",  64'(mem_addr),  64'(1));
    tick();
    check("lat c2 valid", 64'(out_valid), 64'(0));
    check("lat c2 rd_en", 64'(mem_rd_en), 64'(0));
    tick();
    check("lat c3 valid", 64'(out_valid), 64'(1));
    check("lat c3 addr",  64'(out_addr),  64'(1));
    check("lat c3 data",  64'(out_data),  64'(3));
    wait_done("basic done");
    check("basic words_sent", 64'(words_sent), 64'(4));
    check("basic range_err",  64'(range_err),  64'(0));
    check("basic rd_cnt",     64'(rd_cnt),     64'(4));
    check_stream_1to4("basic");
    fin = 1'b0;
    tick();
    check("basic done clr", 64'(done), 64'(0));

    // Stalled dump with a fin re-edge mid-dump (ignored)
    out_ready = 1'b0;
    clear_mon();
    fin = 1'b1;
    tick();
    for (int w = 0; w < 4; w++) begin
      wait_valid($sformatf("stall wait%0d", w));
      for (int s = 0; s < 5; s++) begin
        if (w == 1 && s == 1) fin = 1'b0;
        if (w == 1 && s == 2) fin = 1'b1;
        tick();
      end
      check($sformatf("stall addr%0d", w),  64'(out_addr),  64'(w + 1));
      check($sformatf("stall data%0d", w),  64'(out_data),  64'((w + 1) * 3));
      check($sformatf("stall valid%0d", w), 64'(out_valid), 64'(1));
      check($sformatf("stall rd%0d", w),    64'(rd_cnt),    64'(w + 1));
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
    end
    wait_done("stall done");
    check("stall words_sent", 64'(words_sent), 64'(4));
    check("stall rd_cnt",     64'(rd_cnt),     64'(4));
    check_stream_1to4("stall");
    repeat (4) tick();
    check("done hold",    64'(done),   64'(1));
    check("done no rerd", 64'(rd_cnt), 64'(4));
    fin = 1'b0;
    tick();
    check("rerun done clr", 64'(done), 64'(0));
    out_ready = 1'b1;
    clear_mon();
    fin = 1'b1;
    wait_done("rerun done");
    check("rerun words_sent", 64'(words_sent), 64'(4));
    check_stream_1to4("rerun");
    fin = 1'b0;
    tick();

    // Top address single word, no wrap
    start_addr = 5'd31; end_addr = 5'd31;
    clear_mon();
    fin = 1'b1;
    wait_done("top done");
    check("top count",      64'(q_addr.size()), 64'(1));
    check("top addr",       64'(q_addr[0]),     64'(31));
    check("top data",       64'(q_data[0]),     64'(93));
    check("top words_sent", 64'(words_sent),    64'(1));
    repeat (3) tick();
    check("top rd_cnt",     64'(rd_cnt),        64'(1));
    check("top valid",      64'(out_valid),     64'(0));
    fin = 1'b0;
    tick();

    // Inverted range
    start_addr = 5'd6; end_addr = 5'd2;
    clear_mon();
    fin = 1'b1;
    tick();
    check("rerr done",       64'(done),       64'(1));
    check("rerr range_err",  64'(range_err),  64'(1));
    check("rerr words_sent", 64'(words_sent), 64'(0));
    check("rerr rd_en",      64'(mem_rd_en),  64'(0));
    repeat (3) tick();
    check("rerr rd_cnt",     64'(rd_cnt),     64'(0));
    fin = 1'b0;
    tick();

    // Reset during HOLD of the second word, then clean restart
    start_addr = 5'd1; end_addr = 5'd4; out_ready = 1'b0;
    clear_mon();
    fin = 1'b1;
    tick();
    wait_valid("abort w0");
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    wait_valid("abort w1");
    check("abort w1 addr", 64'(out_addr), 64'(2));
    pcclr = 1'b0; fin = 1'b0;
    tick();
    check_reset_outputs("abort");
    pcclr = 1'b1;
    tick();
    clear_mon();
    out_ready = 1'b1;
    fin = 1'b1;
    wait_done("restart done");
    check("restart words_sent", 64'(words_sent), 64'(4));
    check_stream_1to4("restart");
    fin = 1'b0;
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
